// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO register pair.
// Results are computed when an op is accepted, held pending, and committed after a fixed busy period.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [3:0] {
    MDU_none  = 4'd0,
    MDU_mult  = 4'd1,
    MDU_multu = 4'd2,
    MDU_div   = 4'd3,
    MDU_divu  = 4'd4,
    MDU_mthi  = 4'd5,
    MDU_mtlo  = 4'd6
  } mdu_op_e;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q;
  logic [31:0] pend_hi, pend_lo;
  logic        pend_wr;

  logic        is_md, is_div;
  logic        accept_md, commit, write_mthi, write_mtlo;

  logic        a_neg, b_neg;
  logic [31:0] abs_a, abs_b, uq, ur, dq, dr;
  logic [63:0] prod_s, prod_u;
  logic [31:0] res_hi, res_lo;
  logic        res_wr;

  assign is_md  = (op == MDU_mult) || (op == MDU_multu) || (op == MDU_div) || (op == MDU_divu);
  assign is_div = (op == MDU_div) || (op == MDU_divu);

  // Signed divide runs on magnitudes so the 0x80000000 / -1 overflow case falls out naturally.
  always_comb begin
    a_neg  = srcA[31];
    b_neg  = srcB[31];
    abs_a  = a_neg ? (~srcA + 32'd1) : srcA;
    abs_b  = b_neg ? (~srcB + 32'd1) : srcB;
    uq     = abs_a / abs_b;
    ur     = abs_a % abs_b;
    dq     = srcA / srcB;
    dr     = srcA % srcB;
    prod_s = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
    prod_u = {32'd0, srcA} * {32'd0, srcB};
  end

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    res_wr = 1'b0;
    case (op)
      MDU_mult: begin
        {res_hi, res_lo} = prod_s;
        res_wr           = 1'b1;
      end
      MDU_multu: begin
        {res_hi, res_lo} = prod_u;
        res_wr           = 1'b1;
      end
      MDU_div: begin
        res_lo = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
        res_hi = a_neg ? (~ur + 32'd1) : ur;
        res_wr = (srcB != '0);
      end
      MDU_divu: begin
        res_lo = dq;
        res_hi = dr;
        res_wr = (srcB != '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && is_md) state_d = S_BUSY;
      S_BUSY:  if (cnt_q == 32'd1) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == S_BUSY);
    accept_md  = (state_q == S_IDLE) && start && is_md;
    commit     = (state_q == S_BUSY) && (cnt_q == 32'd1);
    write_mthi = (state_q == S_IDLE) && start && (op == MDU_mthi);
    write_mtlo = (state_q == S_IDLE) && start && (op == MDU_mtlo);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi      <= '0;
      lo      <= '0;
      cnt_q   <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else begin
      if (accept_md) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        pend_wr <= res_wr;
        cnt_q   <= is_div ? DIV_CYCLES : MULT_CYCLES;
      end else if (busy) begin
        cnt_q <= cnt_q - 32'd1;
      end
      // A zero divisor still occupies the full window but leaves HI/LO untouched.
      if (commit && pend_wr) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
      if (write_mthi) hi <= srcA;
      if (write_mtlo) lo <= srcA;
    end
  end

endmodule
